// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of mem_port_arbiter.
// "slave" is the arbiter view; "master" is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access, D-priority
// with IF anti-starvation. Optional watchdog abort is built when MEMARB_WDOG_EN is defined.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I} state_t;

  state_t            state_q;
  logic [SW-1:0]     starve_q;
  logic              mem_req_q, mem_we_q, if_ack_q, d_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
  logic              if_prio, wd_to;

  assign if_prio = bus.if_req && (starve_q == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.d_req && !if_prio) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            if (bus.if_req && starve_q != SW'(STARVE_MAX))
              starve_q <= starve_q + 1'b1;
          end else if (bus.if_req) begin
            state_q    <= BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            starve_q   <= '0;
          end
        end
        BUSY_D, BUSY_I: begin
          // wd_to is only ever set while mem_ready is low, so it selects the abort data
          if (bus.mem_ready || wd_to) begin
            mem_req_q <= 1'b0;
            if (state_q == BUSY_D) begin
              state_q   <= DONE_D;
              d_ack_q   <= 1'b1;
              d_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end else begin
              state_q    <= DONE_I;
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEMARB_WDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_q;
  logic          err_q, busy;

  assign busy  = (state_q == BUSY_D) || (state_q == BUSY_I);
  assign wd_to = busy && !bus.mem_ready && (wait_q == TW'(TIMEOUT - 1));

  // IDLE always precedes BUSY, so clearing there clears on entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wd_to;
      if (state_q == IDLE)
        wait_q <= '0;
      else if (busy && !bus.mem_ready && !wd_to)
        wait_q <= wait_q + 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_to   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.stall     = (bus.d_req & ~d_ack_q) | (bus.if_req & ~if_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timeline checks, then random IF/D traffic against
// a transaction-level reference with a scoreboard monitor.
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } tx_t;

  typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;

  int n_cmp = 0, n_bad = 0;
  tx_t dq[$], iq[$];
  logic [31:0] ref_ram [16];
  logic [31:0] ram [16];
  bit   d_gr, i_gr, mon_en = 1'b0;
  int   wait_cfg = 0;
  bit   ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ram_init(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory environment: IF region (addr bit 12 set) is ROM, D region is a 16-word RAM
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= ram_init(i);
    end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
      ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  initial begin
    int  wait_left;
    bit  mreq_prev;
    wait_left = 0;
    mreq_prev = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (!mreq_prev) wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        if (wait_left == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = ovr_en ? ovr_data :
                          bus.mem_addr[12] ? rom(bus.mem_addr) : ram[bus.mem_addr[5:2]];
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        // junk outside an access; the arbiter must ignore it
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      mreq_prev = bus.mem_req;
    end
  end

  // Scoreboard monitor: grant order from the starvation rule, data from the queued expectations
  initial begin
    mph_t mph;
    tx_t  cur;
    bit   win_d;
    int   losses, nq;
    mph = M_IDLE; losses = 0; win_d = 1'b0;
    cur = '{addr: '0, we: 1'b0, wdata: '0, rdata: '0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mph = M_IDLE; losses = 0; d_gr = 1'b0; i_gr = 1'b0;
      end else begin
        chk("stall", bus.stall, (bus.d_req & ~bus.d_ack) | (bus.if_req & ~bus.if_ack));
        case (mph)
          M_IDLE: begin
            chk("idle_quiet", {bus.mem_req, bus.d_ack, bus.if_ack}, 0);
            if (bus.d_req || bus.if_req) begin
              win_d = bus.d_req && !(bus.if_req && losses == SMAX);
              if (win_d && bus.if_req && losses < SMAX) losses++;
              if (!win_d) losses = 0;
              nq = win_d ? dq.size() : iq.size();
              chk("grant_has_tx", 32'(nq > 0), 1);
              if (nq > 0) begin
                cur  = win_d ? dq[0] : iq[0];
                d_gr = win_d;
                i_gr = !win_d;
                mph  = M_BUSY;
              end
            end
          end
          M_BUSY: begin
            chk("busy_mreq", bus.mem_req, 1);
            chk("busy_addr", bus.mem_addr, cur.addr);
            chk("busy_we", bus.mem_we, cur.we);
            if (cur.we) chk("busy_wdata", bus.mem_wdata, cur.wdata);
            chk("busy_noack", {bus.d_ack, bus.if_ack}, 0);
            if (bus.mem_ready) mph = M_DONE;
          end
          default: begin
            chk("done_mreq", bus.mem_req, 0);
            chk("done_ack", {bus.d_ack, bus.if_ack}, win_d ? 2'b10 : 2'b01);
            chk("done_err", bus.err, 0);
            if (!cur.we) chk("done_rdata", win_d ? bus.d_rdata : bus.if_rdata, cur.rdata);
            if (win_d) void'(dq.pop_front());
            else       void'(iq.pop_front());
            d_gr = 1'b0; i_gr = 1'b0;
            mph  = M_IDLE;
          end
        endcase
      end
    end
  end

  task automatic run_d(input int n);
    tx_t t;
    int  idx, to;
    for (int k = 0; k < n; k++) begin
      idx     = int'($urandom_range(0, 15));
      t.addr  = 32'(idx) << 2;
      t.we    = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      t.rdata = t.we ? '0 : ref_ram[idx];
      if (t.we) ref_ram[idx] = t.wdata;
      dq.push_back(t);
      bus.d_req = 1'b1; bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata;
      to = 0;
      do begin
        @(posedge clk); #1; to++;
        // after grant, dropping the request or changing fields must not matter
        if (!bus.d_ack && d_gr)
          case ($urandom_range(0, 3))
            0: bus.d_req = 1'b0;
            1: begin bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = ~bus.d_we; end
            default: ;
          endcase
      end while (!bus.d_ack && to < 100);
      if (to >= 100) chk("d_ack_timeout", bus.d_ack, 1);
      if ($urandom_range(0, 2) == 0) begin
        bus.d_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    bus.d_req = 1'b0;
  endtask

  task automatic run_i(input int n);
    tx_t t;
    int  to;
    for (int k = 0; k < n; k++) begin
      t.addr  = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
      t.we    = 1'b0;
      t.wdata = '0;
      t.rdata = rom(t.addr);
      iq.push_back(t);
      bus.if_req = 1'b1; bus.if_addr = t.addr;
      to = 0;
      do begin
        @(posedge clk); #1; to++;
        if (!bus.if_ack && i_gr)
          case ($urandom_range(0, 3))
            0: bus.if_req = 1'b0;
            1: bus.if_addr = $urandom;
            default: ;
          endcase
      end while (!bus.if_ack && to < 100);
      if (to >= 100) chk("if_ack_timeout", bus.if_ack, 1);
      if ($urandom_range(0, 3) == 0) begin
        bus.if_req = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    bus.if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {bus.mem_req, bus.mem_we, bus.if_ack, bus.d_ack, bus.err, bus.stall}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b1;

    // zero-wait load at 0x40
    ovr_en = 1'b1; ovr_data = 32'h1234_5678; wait_cfg = 0;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    nx(1); chk("dl_stall_t", bus.stall, 1);
    nx(1); chk("dl_mreq", bus.mem_req, 1); chk("dl_maddr", bus.mem_addr, 32'h40);
    chk("dl_mwe", bus.mem_we, 0); chk("dl_noack", bus.d_ack, 0); chk("dl_stall_t1", bus.stall, 1);
    nx(1); chk("dl_ack", bus.d_ack, 1); chk("dl_rdata", bus.d_rdata, 32'h1234_5678);
    chk("dl_stall_ack", bus.stall, 0);
    bus.d_req = 1'b0;
    nx(1); chk("dl_ack_pulse", {bus.d_ack, bus.mem_req}, 0);
    ovr_en = 1'b0;

    // simultaneous store + fetch
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4; bus.d_wdata = 32'hA5A5_A5A5;
    bus.if_req = 1'b1; bus.if_addr = 32'h1010;
    nx(2); chk("sim_we", bus.mem_we, 1); chk("sim_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    nx(1); chk("sim_d_ack", {bus.d_ack, bus.if_ack}, 2'b10);
    bus.d_req = 1'b0;
    nx(1); chk("sim_done_gap", bus.mem_req, 0);
    nx(1); chk("sim_if_addr", bus.mem_addr, 32'h1010);
    nx(1); chk("sim_if_ack", bus.if_ack, 1); chk("sim_if_rdata", bus.if_rdata, rom(32'h1010));
    bus.if_req = 1'b0;

    // three wait states on a store
    wait_cfg = 3;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h0BAD_F00D;
    nx(1);
    for (int i = 0; i < 4; i++) begin
      nx(1);
      chk("ws_mreq", {bus.mem_req, bus.mem_we, bus.d_ack}, 3'b110);
      chk("ws_addr", bus.mem_addr, 32'h8);
      chk("ws_wdata", bus.mem_wdata, 32'h0BAD_F00D);
    end
    nx(1); chk("ws_ack", bus.d_ack, 1);
    bus.d_req = 1'b0;

    // reset while a fetch is waiting
    wait_cfg = 5;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1004;
    nx(2); chk("rb_busy", bus.mem_req, 1);
    rst = 1'b0; bus.if_req = 1'b0;
    nx(1); chk("rb_mreq_drop", {bus.mem_req, bus.if_ack}, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx(1); chk("rb_no_ack", {bus.mem_req, bus.if_ack}, 0);
    end
    wait_cfg = 0;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    nx(2); chk("rb_idle_grant", bus.mem_req, 1); chk("rb_idle_addr", bus.mem_addr, 32'h20);
    nx(1); chk("rb_idle_ack", bus.d_ack, 1);
    bus.d_req = 1'b0;

`ifdef MEMARB_WDOG_EN
    wait_cfg = 1000;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    nx(1);
    for (int i = 0; i < 15; i++) begin
      nx(1); chk("wd_busy", {bus.mem_req, bus.d_ack, bus.err}, 3'b100);
    end
    nx(1); chk("wd_abort", {bus.mem_req, bus.d_ack, bus.err}, 3'b011);
    chk("wd_rdata", bus.d_rdata, 0);
    bus.d_req = 1'b0;
    nx(1); chk("wd_err_pulse", bus.err, 0);
`endif

    // random traffic under the scoreboard
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_ram[i] = ram_init(i);
    wait_cfg = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    fork
      run_d(80);
      run_i(80);
    join
    nx(8);
    chk("dq_drained", dq.size(), 0);
    chk("iq_drained", iq.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
